// File: rtl/load_store_queue.sv
// In-order load/store queue: a unified request FIFO feeding the data-memory port,
// plus a pending-load FIFO that aligns and extends returned words for write-back.
module load_store_queue #(
    parameter int C_XLEN            = 32,
    parameter int C_DEPTH           = 4,
    parameter int C_MAX_OUTSTANDING = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clk_en_i,
    input  logic              ex_lq_wr_i,
    input  logic              ex_sq_wr_i,
    input  logic [2:0]        ex_funct3_i,
    input  logic [4:0]        ex_regd_addr_i,
    input  logic [C_XLEN-1:0] ex_regs2_data_i,
    input  logic [C_XLEN-1:0] ex_addr_i,
    output logic              ex_lq_full_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [C_XLEN-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [C_XLEN-1:0] dmem_wdata_o,
    input  logic              dmem_ack_i,
    input  logic              dmem_rvalid_i,
    input  logic [C_XLEN-1:0] dmem_rdata_i,
    output logic              regd_wr_o,
    output logic [4:0]        regd_addr_o,
    output logic [C_XLEN-1:0] regd_data_o,
    output logic              misalign_o,
    output logic [C_XLEN-1:0] misalign_addr_o
);
    localparam int QAW = $clog2(C_DEPTH);
    localparam int QCW = QAW + 1;
    localparam int PAW = (C_MAX_OUTSTANDING > 1) ? $clog2(C_MAX_OUTSTANDING) : 1;
    localparam int PCW = $clog2(C_MAX_OUTSTANDING) + 1;

    logic              r_q_store [C_DEPTH];
    logic [2:0]        r_q_f3    [C_DEPTH];
    logic [4:0]        r_q_rd    [C_DEPTH];
    logic [C_XLEN-1:0] r_q_addr  [C_DEPTH];
    logic [C_XLEN-1:0] r_q_data  [C_DEPTH];
    logic [QAW-1:0]    r_wr_ptr;
    logic [QAW-1:0]    r_rd_ptr;
    logic [QCW-1:0]    r_count;

    logic [2:0]        r_p_f3  [C_MAX_OUTSTANDING];
    logic [4:0]        r_p_rd  [C_MAX_OUTSTANDING];
    logic [1:0]        r_p_off [C_MAX_OUTSTANDING];
    logic [PAW-1:0]    r_p_wr_ptr;
    logic [PAW-1:0]    r_p_rd_ptr;
    logic [PCW-1:0]    r_p_count;

    logic              r_regd_wr;
    logic [4:0]        r_regd_addr;
    logic [C_XLEN-1:0] r_regd_data;
    logic              r_mis;
    logic [C_XLEN-1:0] r_mis_addr;

    logic              w_is_store;
    logic              w_misaligned;
    logic              w_enq_try;
    logic              w_enq;
    logic              w_empty;
    logic              w_h_store;
    logic [2:0]        w_h_f3;
    logic [4:0]        w_h_rd;
    logic [C_XLEN-1:0] w_h_addr;
    logic [C_XLEN-1:0] w_h_data;
    logic              w_req;
    logic              w_deq;
    logic              w_lpush;
    logic              w_rpop;
    logic [3:0]        w_be;
    logic [C_XLEN-1:0] w_wdata;
    logic [2:0]        w_p_f3;
    logic [4:0]        w_p_rd;
    logic [1:0]        w_p_off;
    logic [C_XLEN-1:0] w_lane;
    logic [C_XLEN-1:0] w_ext;

    function automatic logic [PAW-1:0] f_pnext(input logic [PAW-1:0] p);
        return (p == PAW'(C_MAX_OUTSTANDING - 1)) ? '0 : p + PAW'(1);
    endfunction

    // Both strobes high is a protocol error; the load wins.
    assign w_is_store = ex_sq_wr_i & ~ex_lq_wr_i;

    always_comb begin
        unique case (ex_funct3_i[1:0])
            2'b00:   w_misaligned = 1'b0;
            2'b01:   w_misaligned = ex_addr_i[0];
            default: w_misaligned = (ex_addr_i[1:0] != 2'b00);
        endcase
    end

    assign w_enq_try = clk_en_i & (ex_lq_wr_i | ex_sq_wr_i) & ~ex_lq_full_o;
    assign w_enq     = w_enq_try & ~w_misaligned;
    assign w_empty   = (r_count == '0);

    assign w_h_store = r_q_store[r_rd_ptr];
    assign w_h_f3    = r_q_f3[r_rd_ptr];
    assign w_h_rd    = r_q_rd[r_rd_ptr];
    assign w_h_addr  = r_q_addr[r_rd_ptr];
    assign w_h_data  = r_q_data[r_rd_ptr];

    assign w_req   = ~w_empty & (w_h_store | (r_p_count < PCW'(C_MAX_OUTSTANDING)));
    assign w_deq   = clk_en_i & w_req & dmem_ack_i;
    assign w_lpush = w_deq & ~w_h_store;
    assign w_rpop  = clk_en_i & dmem_rvalid_i & (r_p_count != '0);

    always_comb begin
        w_be    = '0;
        w_wdata = '0;
        if (!w_empty) begin
            unique case (w_h_f3[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << w_h_addr[1:0];
                    w_wdata = {4{w_h_data[7:0]}};
                end
                2'b01: begin
                    w_be    = w_h_addr[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{w_h_data[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = w_h_data;
                end
            endcase
            if (!w_h_store) w_wdata = '0;
        end
    end

    assign w_p_f3  = r_p_f3[r_p_rd_ptr];
    assign w_p_rd  = r_p_rd[r_p_rd_ptr];
    assign w_p_off = r_p_off[r_p_rd_ptr];

    always_comb begin
        w_lane = dmem_rdata_i >> {w_p_off, 3'b000};
        unique case (w_p_f3)
            3'b000:  w_ext = {{(C_XLEN-8){w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_ext = {{(C_XLEN-16){w_lane[15]}}, w_lane[15:0]};
            3'b100:  w_ext = {{(C_XLEN-8){1'b0}}, w_lane[7:0]};
            3'b101:  w_ext = {{(C_XLEN-16){1'b0}}, w_lane[15:0]};
            default: w_ext = dmem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_p_wr_ptr  <= '0;
            r_p_rd_ptr  <= '0;
            r_p_count   <= '0;
            r_regd_wr   <= 1'b0;
            r_regd_addr <= '0;
            r_regd_data <= '0;
            r_mis       <= 1'b0;
            r_mis_addr  <= '0;
        end else if (clk_en_i) begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + QAW'(1);
            if (w_deq) r_rd_ptr <= r_rd_ptr + QAW'(1);
            if (w_enq && !w_deq)      r_count <= r_count + QCW'(1);
            else if (!w_enq && w_deq) r_count <= r_count - QCW'(1);

            if (w_lpush) r_p_wr_ptr <= f_pnext(r_p_wr_ptr);
            if (w_rpop)  r_p_rd_ptr <= f_pnext(r_p_rd_ptr);
            if (w_lpush && !w_rpop)      r_p_count <= r_p_count + PCW'(1);
            else if (!w_lpush && w_rpop) r_p_count <= r_p_count - PCW'(1);

            // Loads to x0 still consume their return slot but never write back.
            r_regd_wr <= w_rpop & (w_p_rd != 5'd0);
            if (w_rpop && (w_p_rd != 5'd0)) begin
                r_regd_addr <= w_p_rd;
                r_regd_data <= w_ext;
            end

            r_mis <= w_enq_try & w_misaligned;
            if (w_enq_try && w_misaligned) r_mis_addr <= ex_addr_i;
        end
    end

    // Payload storage needs no reset: outputs are masked while the queue is empty.
    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_q_store[r_wr_ptr] <= w_is_store;
            r_q_f3[r_wr_ptr]    <= ex_funct3_i;
            r_q_rd[r_wr_ptr]    <= ex_regd_addr_i;
            r_q_addr[r_wr_ptr]  <= ex_addr_i;
            r_q_data[r_wr_ptr]  <= ex_regs2_data_i;
        end
        if (w_lpush) begin
            r_p_f3[r_p_wr_ptr]  <= w_h_f3;
            r_p_rd[r_p_wr_ptr]  <= w_h_rd;
            r_p_off[r_p_wr_ptr] <= w_h_addr[1:0];
        end
    end

    assign ex_lq_full_o    = (r_count == QCW'(C_DEPTH));
    assign dmem_req_o      = w_req;
    assign dmem_we_o       = ~w_empty & w_h_store;
    assign dmem_addr_o     = w_empty ? '0 : {w_h_addr[C_XLEN-1:2], 2'b00};
    assign dmem_be_o       = w_be;
    assign dmem_wdata_o    = w_wdata;
    assign regd_wr_o       = r_regd_wr;
    assign regd_addr_o     = r_regd_addr;
    assign regd_data_o     = r_regd_data;
    assign misalign_o      = r_mis;
    assign misalign_addr_o = r_mis_addr;

endmodule

// File: tb/tb_load_store_queue.sv
// Scoreboard bench for load_store_queue: a transaction-level queue model predicts
// memory requests, write-backs and misalignment strobes from the driven stimulus.
module tb_load_store_queue;
    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int MAXO  = 2;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        clk_en_i;
    logic        ex_lq_wr_i;
    logic        ex_sq_wr_i;
    logic [2:0]  ex_funct3_i;
    logic [4:0]  ex_regd_addr_i;
    logic [31:0] ex_regs2_data_i;
    logic [31:0] ex_addr_i;
    logic        ex_lq_full_o;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i    = 1'b0;
    logic        dmem_rvalid_i = 1'b0;
    logic [31:0] dmem_rdata_i  = '0;
    logic        regd_wr_o;
    logic [4:0]  regd_addr_o;
    logic [31:0] regd_data_o;
    logic        misalign_o;
    logic [31:0] misalign_addr_o;

    load_store_queue #(
        .C_XLEN(XLEN),
        .C_DEPTH(DEPTH),
        .C_MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .clk_en_i(clk_en_i),
        .ex_lq_wr_i(ex_lq_wr_i), .ex_sq_wr_i(ex_sq_wr_i), .ex_funct3_i(ex_funct3_i),
        .ex_regd_addr_i(ex_regd_addr_i), .ex_regs2_data_i(ex_regs2_data_i), .ex_addr_i(ex_addr_i),
        .ex_lq_full_o(ex_lq_full_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
        .regd_wr_o(regd_wr_o), .regd_addr_o(regd_addr_o), .regd_data_o(regd_data_o),
        .misalign_o(misalign_o), .misalign_addr_o(misalign_addr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic we; logic [2:0] f3; logic [4:0] rd; logic [31:0] addr; logic [31:0] data; } ent_t;
    typedef struct { int due; logic [4:0] rd; logic [31:0] data; } wb_t;
    typedef struct { int due; logic [31:0] addr; } mis_t;

    ent_t mq[$];
    ent_t pq[$];
    wb_t  wbq[$];
    mis_t misq[$];
    int   total = 0;
    int   bad   = 0;
    int   en_cyc = 0;
    bit   last_en = 1'b0;

    int          ack_mode = 1;
    int          rv_mode  = 0;
    bit          fix_en   = 1'b0;
    logic [31:0] fix_val  = '0;

    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] m_be(input ent_t e);
        int sz;
        sz = acc_size(e.f3);
        return 4'(((1 << sz) - 1) << int'(e.addr % 4));
    endfunction

    function automatic logic [31:0] m_wdata(input ent_t e);
        logic [31:0] w;
        int sz;
        w  = '0;
        sz = acc_size(e.f3);
        if (!e.we) return '0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = e.data[8*(i % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input ent_t e, input logic [31:0] word);
        logic [31:0] s;
        int v;
        s = word >> (8 * int'(e.addr % 4));
        case (e.f3)
            3'b000: begin v = int'(s & 32'hFF);   if (v > 127)   v -= 256;   return 32'(v); end
            3'b001: begin v = int'(s & 32'hFFFF); if (v > 32767) v -= 65536; return 32'(v); end
            3'b100: return s & 32'hFF;
            3'b101: return s & 32'hFFFF;
            default: return word;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor + model: compare the current outputs, then advance the model by the
    // inputs that the coming rising edge will sample.
    always @(negedge clk_i) begin
        bit   mreq;
        ent_t n;
        ent_t h;
        ent_t e;
        wb_t  w;
        mis_t m;
        if (reset_i) begin
            chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
            chk("rst_full", {31'd0, ex_lq_full_o}, 32'd0);
            chk("rst_regd_wr", {31'd0, regd_wr_o}, 32'd0);
            chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
            chk("rst_addr", dmem_addr_o, 32'd0);
            chk("rst_wdata", dmem_wdata_o, 32'd0);
            chk("rst_regd_data", regd_data_o, 32'd0);
            chk("rst_mis_addr", misalign_addr_o, 32'd0);
            mq.delete(); pq.delete(); wbq.delete(); misq.delete();
            last_en = 1'b0;
        end else begin
            mreq = (mq.size() > 0) && (mq[0].we || pq.size() < MAXO);
            chk("full", {31'd0, ex_lq_full_o}, {31'd0, mq.size() == DEPTH});
            chk("req", {31'd0, dmem_req_o}, {31'd0, mreq});
            if (mreq) begin
                chk("we", {31'd0, dmem_we_o}, {31'd0, mq[0].we});
                chk("addr", dmem_addr_o, mq[0].addr & 32'hFFFF_FFFC);
                chk("be", {28'd0, dmem_be_o}, {28'd0, m_be(mq[0])});
                chk("wdata", dmem_wdata_o, m_wdata(mq[0]));
            end
            if (last_en) begin
                if (regd_wr_o) begin
                    if (wbq.size() == 0) begin
                        chk("wb_unexpected", {31'd0, regd_wr_o}, 32'd0);
                    end else begin
                        w = wbq.pop_front();
                        chk("wb_cycle", en_cyc, w.due);
                        chk("wb_rd", {27'd0, regd_addr_o}, {27'd0, w.rd});
                        chk("wb_data", regd_data_o, w.data);
                    end
                end else if (wbq.size() > 0 && wbq[0].due <= en_cyc) begin
                    w = wbq.pop_front();
                    chk("wb_missing", {31'd0, regd_wr_o}, 32'd1);
                end
                if (misalign_o) begin
                    if (misq.size() == 0) begin
                        chk("mis_unexpected", {31'd0, misalign_o}, 32'd0);
                    end else begin
                        m = misq.pop_front();
                        chk("mis_cycle", en_cyc, m.due);
                        chk("mis_addr", misalign_addr_o, m.addr);
                    end
                end else if (misq.size() > 0 && misq[0].due <= en_cyc) begin
                    m = misq.pop_front();
                    chk("mis_missing", {31'd0, misalign_o}, 32'd1);
                end
            end
            if (clk_en_i) begin
                if (dmem_rvalid_i && pq.size() > 0) begin
                    e = pq.pop_front();
                    if (e.rd != 5'd0) wbq.push_back('{en_cyc + 1, e.rd, m_load(e, dmem_rdata_i)});
                end
                if ((ex_lq_wr_i || ex_sq_wr_i) && mq.size() < DEPTH) begin
                    if ((ex_addr_i % acc_size(ex_funct3_i)) != 0) begin
                        misq.push_back('{en_cyc + 1, ex_addr_i});
                    end else begin
                        n.we   = ex_sq_wr_i && !ex_lq_wr_i;
                        n.f3   = ex_funct3_i;
                        n.rd   = ex_regd_addr_i;
                        n.addr = ex_addr_i;
                        n.data = ex_regs2_data_i;
                        mq.push_back(n);
                    end
                end
                if (mreq && dmem_ack_i) begin
                    h = mq.pop_front();
                    if (!h.we) pq.push_back(h);
                end
                en_cyc++;
                last_en = 1'b1;
            end else begin
                last_en = 1'b0;
            end
        end
    end

    // Memory responder: modes are sampled at the edge, driven just after it.
    always @(posedge clk_i) begin
        int am;
        int rm;
        int np;
        am = ack_mode;
        rm = rv_mode;
        np = pq.size();
        #1;
        dmem_ack_i = (am == 1) ? 1'b1 : (am == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (rm == 2)      dmem_rvalid_i = 1'b1;
        else if (rm == 1) dmem_rvalid_i = (np > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
        else              dmem_rvalid_i = 1'b0;
        dmem_rdata_i = fix_en ? fix_val : $urandom();
    end

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic issue(input logic lq, input logic sq, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] a, input logic [31:0] d);
        ex_lq_wr_i = lq; ex_sq_wr_i = sq; ex_funct3_i = f3;
        ex_regd_addr_i = rd; ex_addr_i = a; ex_regs2_data_i = d;
        cyc();
        ex_lq_wr_i = 1'b0; ex_sq_wr_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before %0t", $time);
        $fatal(1);
    end

    initial begin
        int          r;
        int          k;
        int          wt;
        logic [2:0]  f;
        logic [31:0] a;
        reset_i = 1'b1; clk_en_i = 1'b1;
        ex_lq_wr_i = 1'b0; ex_sq_wr_i = 1'b0; ex_funct3_i = '0;
        ex_regd_addr_i = '0; ex_regs2_data_i = '0; ex_addr_i = '0;
        idle(3);
        reset_i = 1'b0;
        idle(2);

        issue(1'b0, 1'b1, 3'b010, 5'd0, 32'h100, 32'hDEADBEEF);
        idle(3);
        issue(1'b0, 1'b1, 3'b000, 5'd0, 32'h203, 32'h0000005A);
        issue(1'b0, 1'b1, 3'b001, 5'd0, 32'h202, 32'h00001234);
        idle(3);

        fix_en = 1'b1; fix_val = 32'h0000_8000; rv_mode = 2;
        issue(1'b1, 1'b0, 3'b000, 5'd5, 32'h301, 32'h0);
        idle(4);
        issue(1'b1, 1'b0, 3'b100, 5'd5, 32'h301, 32'h0);
        idle(4);
        fix_en = 1'b0; rv_mode = 0;

        ack_mode = 0;
        idle(2);
        for (int i = 0; i < 5; i++) issue(1'b1, 1'b0, 3'b010, 5'(i + 1), 32'h400 + 32'(4 * i), 32'h0);
        idle(2);
        ack_mode = 1;
        idle(6);
        rv_mode = 1;
        idle(25);

        issue(1'b1, 1'b0, 3'b010, 5'd7, 32'h102, 32'h0);
        idle(3);

        ack_mode = 0; rv_mode = 0;
        idle(2);
        for (int i = 0; i < 3; i++) issue(1'b1, 1'b0, 3'b010, 5'(i + 9), 32'h500 + 32'(4 * i), 32'h0);
        ack_mode = 1;
        idle(1);
        ack_mode = 0;
        idle(3);
        reset_i = 1'b1;
        idle(1);
        reset_i = 1'b0;
        rv_mode = 2;
        idle(4);
        rv_mode = 1; ack_mode = 2;

        for (int c = 0; c < 3000; c++) begin
            r = $urandom_range(0, 99);
            clk_en_i = ($urandom_range(0, 9) != 0);
            reset_i  = (c == 1500);
            ex_lq_wr_i = 1'b0; ex_sq_wr_i = 1'b0;
            if (r < 60) begin
                k = $urandom_range(0, 9);
                f = 3'($urandom_range(0, 7));
                a = $urandom();
                if ($urandom_range(0, 3) != 0) a = a & ~32'(acc_size(f) - 1);
                ex_lq_wr_i = (k < 5) || (k == 9);
                ex_sq_wr_i = (k >= 5);
                ex_funct3_i = f;
                ex_addr_i = a;
                ex_regd_addr_i = 5'($urandom_range(0, 31));
                ex_regs2_data_i = $urandom();
            end
            cyc();
        end

        ex_lq_wr_i = 1'b0; ex_sq_wr_i = 1'b0; clk_en_i = 1'b1; reset_i = 1'b0;
        ack_mode = 1; rv_mode = 1;
        wt = 0;
        while ((mq.size() + pq.size() + wbq.size() + misq.size()) != 0 && wt < 300) begin
            cyc();
            wt++;
        end
        chk("drain_left", 32'(mq.size() + pq.size() + wbq.size() + misq.size()), 32'd0);
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_queue.md
Name: load_store_queue

Overview:
In-order load/store queue between the execute stage and the data-memory port. It accepts load and store requests from the execute stage and buffers them in a unified FIFO. It issues them to data memory over a req/ack handshake and tracks outstanding loads. Returned load data is aligned and sign/zero-extended, then written back to the register file.

Parameters:
C_XLEN, 32, data/address width (fixed 32 for RV32I)
C_DEPTH, 4, queue entries (power of 2, >=2)
C_MAX_OUTSTANDING, 2, loads issued but not yet returned (power of 2, >=1)

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
clk_en_i  in  1  global clock enable; gates every state update and handshake
ex_lq_wr_i  in  1  enqueue load
ex_sq_wr_i  in  1  enqueue store
ex_funct3_i  in  3  RV32I load/store funct3
ex_regd_addr_i  in  5  load destination register
ex_regs2_data_i  in  C_XLEN  store data
ex_addr_i  in  C_XLEN  effective address
ex_lq_full_o  out  1  queue full; enqueue is dropped while high
dmem_req_o  out  1  memory request valid
dmem_we_o  out  1  1=store
dmem_addr_o  out  C_XLEN  word-aligned address ({addr[31:2],2'b00})
dmem_be_o  out  4  byte enables
dmem_wdata_o  out  C_XLEN  lane-replicated store data
dmem_ack_i  in  1  request accepted (transfer when req&ack&clk_en)
dmem_rvalid_i  in  1  load data valid, in issue order
dmem_rdata_i  in  C_XLEN  load word
regd_wr_o  out  1  write-back strobe
regd_addr_o  out  5  write-back register
regd_data_o  out  C_XLEN  extended load data
misalign_o  out  1  one-cycle misaligned-access strobe
misalign_addr_o  out  C_XLEN  faulting address

Behaviour:
- Reset: FIFO and pending-load counters = 0. ex_lq_full_o=0, dmem_req_o=0, regd_wr_o=0, misalign_o=0. All data outputs = 0.
- Enqueue:
  - Occurs when clk_en_i & (ex_lq_wr_i|ex_sq_wr_i) & !ex_lq_full_o.
  - If both ex_lq_wr_i and ex_sq_wr_i are high, the request is a load (protocol error, lq priority).
  - Entry stores {is_store, funct3, regd, addr, data}.
  - ex_lq_full_o = (count==C_DEPTH), driven from registered count. There is no bypass: enqueue while full is dropped even if a dequeue happens that cycle.
- Misalignment:
  - Checked at enqueue. Halfword (funct3[1:0]=01) with addr[0]=1, or word (10) with addr[1:0]!=0, is misaligned.
  - A misaligned request is not stored. Next cycle misalign_o=1 and misalign_addr_o=addr.
  - funct3 011/110/111 is treated as word.
- Issue:
  - dmem_req_o = !empty & (head is store | pending_loads < C_MAX_OUTSTANDING). Outputs are driven from the head entry register.
  - An entry written into an empty queue in cycle N is presented in cycle N+1.
  - Head pops on req&ack&clk_en_i. A load pop increments pending_loads.
  - req and its payload stay stable until ack.
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{data[7:0]}}.
  - SH: be=addr[1]?4'b1100:4'b0011, wdata={2{data[15:0]}}.
  - SW: be=4'b1111, wdata=data.
- Load be: same patterns as stores; dmem_wdata_o=0 for loads.
- Pending-load FIFO: holds {funct3, regd, addr[1:0]} per issued load. rvalid pops it; rvalid while empty is ignored.
- Simultaneous load issue and rvalid: pending_loads count unchanged; both FIFO pointers advance.
- Write-back:
  - Registered. rvalid in cycle M gives regd_wr_o=1 in M+1 for exactly one cycle.
  - Byte/half selected by stored addr[1:0].
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word.
  - regd=x0: load is issued, regd_wr_o stays 0.
- Stores expect no rvalid.
- Reset mid-operation clears queue and pending loads immediately. Late rvalid after reset is ignored.
- clk_en_i=0: all registers hold; strobes (regd_wr_o, misalign_o) hold their value.

Test Plan:
1. SW addr 0x100 data 0xDEADBEEF into empty queue, ack tied 1 -> next cycle dmem_req_o=1, we=1, addr=0x100, be=1111, wdata=0xDEADBEEF; queue empty after.
2. SB addr 0x203 data 0x5A -> be=1000, wdata=0x5A5A5A5A, addr=0x200; SH addr 0x202 -> be=1100.
3. LB to x5 at 0x301, rdata=0x0000_8000 -> regd_wr_o=1, regd_addr_o=5, regd_data_o=0xFFFFFF80 one cycle after rvalid; LBU same -> 0x00000080.
4. ack=0, enqueue 5 loads with C_DEPTH=4 -> ex_lq_full_o=1 after 4th, 5th dropped. Release ack, withhold rvalid -> only 2 issued (C_MAX_OUTSTANDING), req drops until rvalid.
5. LW at 0x102 -> not enqueued, misalign_o=1 for one cycle, misalign_addr_o=0x102, no dmem_req_o.
6. Assert reset_i with 2 queued, 1 pending -> dmem_req_o=0, ex_lq_full_o=0 immediately; subsequent rvalid produces no regd_wr_o.
